// File: rtl/regfile_wb_arbiter_if.sv
// Writeback bus between the two result sources and the register-file write port.
// master: the requesters (pipeline and multi-cycle unit); slave: the arbiter.
interface regfile_wb_arbiter_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    logic              valid_a;
    logic [ADDR_W-1:0] waddr_a;
    logic [DATA_W-1:0] wdata_a;
    logic              ready_a;

    logic              valid_b;
    logic [ADDR_W-1:0] waddr_b;
    logic [DATA_W-1:0] wdata_b;
    logic              ready_b;

    logic              we;
    logic [ADDR_W-1:0] waddr;
    logic [DATA_W-1:0] wdata;
    logic              grant_b;

    modport master (
        output valid_a, waddr_a, wdata_a,
        output valid_b, waddr_b, wdata_b,
        input  ready_a, ready_b,
        input  we, waddr, wdata, grant_b
    );

    modport slave (
        input  valid_a, waddr_a, wdata_a,
        input  valid_b, waddr_b, wdata_b,
        output ready_a, ready_b,
        output we, waddr, wdata, grant_b
    );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Register-file write-port arbiter: port A (pipeline) has fixed priority over port B (multi-cycle unit).
// Define WB_STARVE_GUARD_EN to build the starvation counter that forces B after STARVE_LIMIT denials.
module regfile_wb_arbiter #(
    parameter int DATA_W       = 32,
    parameter int ADDR_W       = 5,
    parameter int STARVE_LIMIT = 4,
    parameter int CNT_W        = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    regfile_wb_arbiter_if.slave  bus
);

    // Index 0 is port A, index 1 is port B.
    logic [1:0]        valid_v;
    logic [1:0]        addr_nz_v;
    logic [1:0]        req_nz_v;
    logic [1:0]        ready_v;
    logic [1:0]        xfer_v;
    logic [ADDR_W-1:0] addr_v [2];
    logic [DATA_W-1:0] data_v [2];

    assign valid_v   = {bus.valid_b, bus.valid_a};
    assign addr_v[0] = bus.waddr_a;
    assign addr_v[1] = bus.waddr_b;
    assign data_v[0] = bus.wdata_a;
    assign data_v[1] = bus.wdata_b;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_port
            assign addr_nz_v[gi] = (addr_v[gi] != '0);
            assign req_nz_v[gi]  = valid_v[gi] && addr_nz_v[gi];
            assign xfer_v[gi]    = valid_v[gi] && ready_v[gi];
        end
    endgenerate

    logic force_b;

`ifdef WB_STARVE_GUARD_EN
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

    logic [CNT_W-1:0] starve_cnt_reg;
    logic [CNT_W-1:0] starve_cnt_next;

    assign force_b = (starve_cnt_reg == LIMIT) && req_nz_v[1];

    always_comb begin
        starve_cnt_next = starve_cnt_reg;
        if (!bus.valid_b || xfer_v[1]) begin
            starve_cnt_next = '0;
        end else if (req_nz_v[1] && !ready_v[1] && (starve_cnt_reg < LIMIT)) begin
            starve_cnt_next = starve_cnt_reg + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            starve_cnt_reg <= '0;
        end else begin
            starve_cnt_reg <= starve_cnt_next;
        end
    end
`else
    // Without the guard A always wins; the sizing parameters are only kept for a common port list.
    logic unused_cfg;
    assign unused_cfg = ^{STARVE_LIMIT[0], CNT_W[0]};
    assign force_b    = 1'b0;
`endif

    // Zero-address requests never occupy the write port, so they are accepted independently.
    assign ready_v[0] = !rst && !(force_b && addr_nz_v[0]);
    assign ready_v[1] = !rst && (!addr_nz_v[1] || force_b || !req_nz_v[0]);

    assign bus.ready_a = ready_v[0];
    assign bus.ready_b = ready_v[1];

    logic              we_reg,      we_next;
    logic [ADDR_W-1:0] waddr_reg,   waddr_next;
    logic [DATA_W-1:0] wdata_reg,   wdata_next;
    logic              grant_b_reg, grant_b_next;

    always_comb begin
        we_next      = 1'b0;
        waddr_next   = waddr_reg;
        wdata_next   = wdata_reg;
        grant_b_next = grant_b_reg;
        if (xfer_v[0] && addr_nz_v[0]) begin
            we_next      = 1'b1;
            waddr_next   = addr_v[0];
            wdata_next   = data_v[0];
            grant_b_next = 1'b0;
        end else if (xfer_v[1] && addr_nz_v[1]) begin
            we_next      = 1'b1;
            waddr_next   = addr_v[1];
            wdata_next   = data_v[1];
            grant_b_next = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            we_reg      <= 1'b0;
            waddr_reg   <= '0;
            wdata_reg   <= '0;
            grant_b_reg <= 1'b0;
        end else begin
            we_reg      <= we_next;
            waddr_reg   <= waddr_next;
            wdata_reg   <= wdata_next;
            grant_b_reg <= grant_b_next;
        end
    end

    assign bus.we      = we_reg;
    assign bus.waddr   = waddr_reg;
    assign bus.wdata   = wdata_reg;
    assign bus.grant_b = grant_b_reg;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Scoreboard bench for regfile_wb_arbiter: a request-level model predicts acceptance and the
// write stream; a monitor compares every register-file write against the expected queue.
module tb_regfile_wb_arbiter;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int LIMIT  = 4;
    localparam int CNT_W  = 3;
`ifdef WB_STARVE_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    regfile_wb_arbiter_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    regfile_wb_arbiter #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .STARVE_LIMIT(LIMIT), .CNT_W(CNT_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int                cyc;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        logic              gb;
    } wr_t;
    wr_t exp_q[$];

    // Model: one outstanding request per port, plus the count of consecutive B denials.
    bit                a_pend, b_pend, rst_v;
    logic [ADDR_W-1:0] a_addr, b_addr;
    logic [DATA_W-1:0] a_data, b_data;
    int                starve;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    function automatic logic [ADDR_W-1:0] rand_addr();
        int r;
        r = $urandom_range(0, 9);
        if (r < 2) return '0;
        if (r < 5) return ADDR_W'($urandom_range(1, 3));
        return ADDR_W'($urandom_range(1, 31));
    endfunction

    // One clock cycle: present pending requests, check ready against the model, apply transfers.
    task automatic step();
        bit a_busy, forced, exp_ra, exp_rb, xa, xb;
        @(posedge clk);
        #1;
        rst         = rst_v;
        bus.valid_a = a_pend; bus.waddr_a = a_addr; bus.wdata_a = a_data;
        bus.valid_b = b_pend; bus.waddr_b = b_addr; bus.wdata_b = b_data;
        #3;
        a_busy = a_pend && (a_addr != 0);
        forced = GUARD && (starve == LIMIT) && b_pend && (b_addr != 0);
        if (rst_v) begin
            exp_ra = 1'b0;
            exp_rb = 1'b0;
        end else begin
            // A owns the write port unless B has been forced; register 0 needs no port.
            exp_ra = (a_addr == 0) || !forced;
            exp_rb = (b_addr == 0) || forced || !a_busy;
        end
        if (a_pend) chk("ready_a", bus.ready_a, exp_ra);
        if (b_pend) chk("ready_b", bus.ready_b, exp_rb);
        xa = a_pend && exp_ra;
        xb = b_pend && exp_rb;
        if (xa && a_addr != 0)      exp_q.push_back('{cyc + 1, a_addr, a_data, 1'b0});
        else if (xb && b_addr != 0) exp_q.push_back('{cyc + 1, b_addr, b_data, 1'b1});
        if (rst_v || !b_pend || xb) starve = 0;
        else if (b_addr != 0 && starve < LIMIT) starve++;
        if (xa) a_pend = 1'b0;
        if (xb) b_pend = 1'b0;
    endtask

    // Monitor: every write must match the next expected entry; idle cycles must hold the outputs.
    logic [ADDR_W-1:0] last_addr = '0;
    logic [DATA_W-1:0] last_data = '0;
    logic              last_gb   = 1'b0;
    initial begin
        wr_t e;
        forever begin
            @(negedge clk);
            if (bus.we === 1'b1) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_write: got addr %0d data %0h, required no write (cycle %0d)",
                             bus.waddr, bus.wdata, cyc);
                end else begin
                    e = exp_q.pop_front();
                    chk("write_cycle", cyc, e.cyc);
                    chk("waddr", bus.waddr, e.addr);
                    chk("wdata", bus.wdata, e.data);
                    chk("grant_b", bus.grant_b, e.gb);
                    last_addr = e.addr;
                    last_data = e.data;
                    last_gb   = e.gb;
                    $display("write cycle=%0d addr=%0d data=%08h grant_b=%0b", cyc, bus.waddr, bus.wdata, bus.grant_b);
                end
            end else begin
                chk("we_idle", bus.we, 1'b0);
                chk("waddr_hold", bus.waddr, last_addr);
                chk("wdata_hold", bus.wdata, last_data);
                chk("grant_b_hold", bus.grant_b, last_gb);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation still running at %0t", $time);
        $fatal(1, "timeout");
    end

    task automatic drain(input string name);
        for (int i = 0; i < 20 && (a_pend || b_pend); i++) step();
        chk(name, {a_pend, b_pend}, 2'b00);
    endtask

    initial begin
        starve = 0;
        rst_v  = 1'b1;
        rst    = 1'b1;
        a_pend = 1'b1; a_addr = 5'd3; a_data = 32'hCAFE0003;
        b_pend = 1'b0; b_addr = '0;   b_data = '0;
        bus.valid_a = a_pend; bus.waddr_a = a_addr; bus.wdata_a = a_data;
        bus.valid_b = 1'b0;   bus.waddr_b = '0;     bus.wdata_b = '0;

        // Reset held two cycles with a pending A request, then released.
        step();
        step();
        rst_v = 1'b0;
        step();

        // Single A write.
        a_pend = 1'b1; a_addr = 5'd5; a_data = 32'h12345678;
        step();

        // Contention: A first, B on the following cycle.
        a_pend = 1'b1; a_addr = 5'd7; a_data = 32'h0000000A;
        b_pend = 1'b1; b_addr = 5'd9; b_data = 32'h0000000B;
        step();
        step();
        drain("contention_done");

        // Zero-address A alongside a real B write.
        a_pend = 1'b1; a_addr = 5'd0; a_data = $urandom;
        b_pend = 1'b1; b_addr = 5'd4; b_data = $urandom;
        step();
        drain("zero_addr_done");
        step();

        // Continuous A traffic against a waiting B.
        b_pend = 1'b1; b_addr = 5'd6; b_data = 32'hB6B6B6B6;
        for (int i = 0; i < 20; i++) begin
            if (!a_pend) begin
                a_pend = 1'b1;
                a_addr = ADDR_W'($urandom_range(1, 31));
                a_data = $urandom;
            end
            step();
        end
        chk("b_starved_state", b_pend, !GUARD);
        drain("starvation_done");

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            if (!a_pend && $urandom_range(0, 9) < 7) begin
                a_pend = 1'b1; a_addr = rand_addr(); a_data = $urandom;
            end
            if (!b_pend && $urandom_range(0, 9) < 5) begin
                b_pend = 1'b1; b_addr = rand_addr(); b_data = $urandom;
            end
            step();
        end
        drain("random_done");
        step();
        step();
        step();
        chk("queue_empty", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/regfile_wb_arbiter.md
# regfile_wb_arbiter

Shares the register file's single write port between two writeback sources: the in-order pipeline writeback (port A) and the multi-cycle unit return path (port B, divider/long-latency results). Accepts requests through valid/ready handshakes, applies fixed priority to A with an optional starvation guard for B, and drives registered `we`/`waddr`/`wdata` into the register file. Writes to register 0 are absorbed without touching the write port.

## Interface
- `DATA_W`, 32, write data width (`RegBus`)
- `ADDR_W`, 5, register address width (`RegAddrBus`)
- `STARVE_LIMIT`, 4, consecutive denied cycles of B before B is forced (guard builds only)
- `CNT_W`, 3, starvation counter width; must hold `STARVE_LIMIT`
- `clk`  in  1  clock; all state updates on rising edge
- `rst`  in  1  reset, synchronous, active-high
- `valid_a`  in  1  pipeline writeback request
- `waddr_a`  in  ADDR_W  destination register, port A
- `wdata_a`  in  DATA_W  data, port A
- `ready_a`  out  1  combinational accept, port A
- `valid_b`  in  1  multi-cycle unit writeback request
- `waddr_b`  in  ADDR_W  destination register, port B
- `wdata_b`  in  DATA_W  data, port B
- `ready_b`  out  1  combinational accept, port B
- `we`  out  1  registered write enable to register file
- `waddr`  out  ADDR_W  registered write address
- `wdata`  out  DATA_W  registered write data
- `grant_b`  out  1  registered; 1 when current `we` originates from B

## Operation
- Transfer on port X when `valid_x && ready_x` in the same cycle.
- Zero-address request (`waddr_x == 0`): `ready_x = 1` whenever `valid_x` and not in reset; transfer completes, no write issued, does not block the other port.
- Nonzero requests: at most one granted per cycle.
  - Default: A wins. `ready_a = 1`; `ready_b = !(valid_a && waddr_a != 0)`.
  - Forced (`force_b` asserted): `ready_a = 0` for nonzero A; `ready_b = 1`.
- Granted nonzero request latched next edge: `we <= 1`, `waddr`, `wdata`, `grant_b` from winner. No nonzero grant: `we <= 0`; `waddr`, `wdata`, `grant_b` hold.
- Same-address collision (A and B valid, equal nonzero address): no special handling; arbitration rule applies, loser waits. Ordering between ports is the issuer's responsibility.
- Inputs must stay stable while `valid_x && !ready_x`; `valid_x` must not drop before transfer.
- Starvation counter `starve_cnt`: increments (saturating at `STARVE_LIMIT`) each cycle `valid_b && waddr_b != 0 && !ready_b`; clears to 0 on any B transfer or when `valid_b == 0`.
- `force_b = (starve_cnt == STARVE_LIMIT) && valid_b && waddr_b != 0`.

## Timing
- Reset values: `we = 0`, `waddr = 0`, `wdata = 0`, `grant_b = 0`, `starve_cnt = 0`.
- While `rst` is high: `ready_a = ready_b = 0`; no transfer on either port. A request pending at reset assertion is neither accepted nor written; the requester re-presents after reset.
- Latency: handshake in cycle N, `we` high in cycle N+1; register file commits at edge ending N+1; its bypass covers reads during N+1.
- Throughput: one nonzero write per cycle; back-to-back grants give continuous `we`.
- Worst case B wait with guard: `STARVE_LIMIT + 1` cycles from first denied cycle to transfer.
- `ready_x` depends combinationally on `valid_*`, `waddr_*`, `starve_cnt`, `rst`; no combinational path from `wdata_*` to `ready_*`.

## Configuration
- `WB_STARVE_GUARD_EN` defined: starvation counter and `force_b` built as above.
- Not defined: no counter; `force_b` constant 0; A always wins; B can starve indefinitely under continuous A traffic. `STARVE_LIMIT` and `CNT_W` unused.

## Test plan
- Reset: hold `rst` 2 cycles with `valid_a = 1`, `waddr_a = 3` -> `ready_a = 0`, `we = 0`, all outputs 0; after release, transfer and `we = 1`, `waddr = 3` one cycle later.
- Single A: `valid_a`, `waddr_a = 5`, `wdata_a = 0x12345678` -> `ready_a = 1`; next cycle `we = 1`, `waddr = 5`, `wdata = 0x12345678`, `grant_b = 0`.
- Contention: A (`7`, `0xA`) and B (`9`, `0xB`) valid together -> A first, `ready_b = 0`; next cycle, A idle, B transfers; `we` high two consecutive cycles, second with `waddr = 9`, `grant_b = 1`.
- Zero address: A `waddr_a = 0` with B `waddr_b = 4` valid -> both ready same cycle; next cycle `we = 1`, `waddr = 4`; no write for A.
- Starvation (guard on, `STARVE_LIMIT = 4`): continuous nonzero A, B valid `waddr_b = 6` -> B denied 4 cycles, transfers on 5th with `ready_a = 0`; counter then 0, A resumes next cycle.
- Guard off: same stimulus for 20 cycles -> B never accepted, `grant_b` stays 0.
